// File: rtl/hist_pkg.sv
// Shared types and defaults for the histogram statistics reader.
// The result struct is sized for the widest supported configuration
// (ADDR_W, CNT_W up to 16); instances zero-extend into it and the top
// slices back down to its own widths.
// Optional feature macro: HIST_STATS_MIN_EN (minimum bin/count tracking).
package hist_pkg;

  localparam int HIST_ADDR_W     = 7;
  localparam int HIST_CNT_W      = 7;

  localparam int HIST_RES_ADDR_W = 16;
  localparam int HIST_RES_CNT_W  = 16;
  localparam int HIST_RES_TOT_W  = HIST_RES_ADDR_W + HIST_RES_CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } hist_state_e;

  typedef struct packed {
    logic [HIST_RES_ADDR_W-1:0] peak_bin;
    logic [HIST_RES_CNT_W-1:0]  peak_count;
    logic [HIST_RES_TOT_W-1:0]  total;
    logic [HIST_RES_ADDR_W:0]   nonzero_bins;
  } hist_result_t;

endpackage

// File: rtl/hist_stats_acc.sv
// Capture-side datapath: folds each returned bin count into the running
// peak / total / non-zero statistics. 'clear' restarts a scan and wins
// over 'valid'. Optional macro HIST_STATS_MIN_EN adds minimum tracking.
module hist_stats_acc
  import hist_pkg::*;
#(
  parameter int ADDR_W = HIST_ADDR_W,
  parameter int CNT_W  = HIST_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CNT_W-1:0]  data,
`ifdef HIST_STATS_MIN_EN
  output logic [ADDR_W-1:0] min_bin,
  output logic [CNT_W-1:0]  min_count,
`endif
  output hist_result_t      result
);

  localparam int TOT_W = ADDR_W + CNT_W;

  logic [ADDR_W-1:0] peak_bin_r;
  logic [CNT_W-1:0]  peak_count_r;
  logic [TOT_W-1:0]  total_r;
  logic [ADDR_W:0]   nonzero_r;

  logic [ADDR_W-1:0] peak_bin_s;
  logic [CNT_W-1:0]  peak_count_s;
  logic [TOT_W-1:0]  total_s;
  logic [ADDR_W:0]   nonzero_s;

  // Next-state of the peak/total/non-zero accumulators.
  always_comb begin
    peak_bin_s   = peak_bin_r;
    peak_count_s = peak_count_r;
    total_s      = total_r;
    nonzero_s    = nonzero_r;
    if (clear) begin
      peak_bin_s   = {ADDR_W{1'b0}};
      peak_count_s = {CNT_W{1'b0}};
      total_s      = {TOT_W{1'b0}};
      nonzero_s    = {(ADDR_W+1){1'b0}};
    end else if (valid) begin
      total_s = total_r + TOT_W'(data);
      if (data != {CNT_W{1'b0}}) begin
        nonzero_s = nonzero_r + (ADDR_W+1)'(1'b1);
      end else begin
        nonzero_s = nonzero_r;
      end
      // Strictly greater: on a tie the earlier (lower) bin is kept.
      if (data > peak_count_r) begin
        peak_count_s = data;
        peak_bin_s   = addr;
      end else begin
        peak_count_s = peak_count_r;
        peak_bin_s   = peak_bin_r;
      end
    end else begin
      total_s = total_r;
    end
  end

  // Accumulator registers; reset clears everything.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      peak_bin_r   <= {ADDR_W{1'b0}};
      peak_count_r <= {CNT_W{1'b0}};
      total_r      <= {TOT_W{1'b0}};
      nonzero_r    <= {(ADDR_W+1){1'b0}};
    end else begin
      peak_bin_r   <= peak_bin_s;
      peak_count_r <= peak_count_s;
      total_r      <= total_s;
      nonzero_r    <= nonzero_s;
    end
  end

`ifdef HIST_STATS_MIN_EN
  logic [ADDR_W-1:0] min_bin_r;
  logic [CNT_W-1:0]  min_count_r;
  logic [ADDR_W-1:0] min_bin_s;
  logic [CNT_W-1:0]  min_count_s;

  // Next-state of the minimum tracker; a scan starts from all-ones.
  always_comb begin
    min_bin_s   = min_bin_r;
    min_count_s = min_count_r;
    if (clear) begin
      min_bin_s   = {ADDR_W{1'b0}};
      min_count_s = {CNT_W{1'b1}};
    end else if (valid && (data < min_count_r)) begin
      min_bin_s   = addr;
      min_count_s = data;
    end else begin
      min_bin_s   = min_bin_r;
      min_count_s = min_count_r;
    end
  end

  // Minimum registers; reset value is zero, not all-ones.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      min_bin_r   <= {ADDR_W{1'b0}};
      min_count_r <= {CNT_W{1'b0}};
    end else begin
      min_bin_r   <= min_bin_s;
      min_count_r <= min_count_s;
    end
  end

  assign min_bin   = min_bin_r;
  assign min_count = min_count_r;
`endif

  // Pack the registered statistics into the shared result struct.
  always_comb begin
    result              = '{default: 1'b0};
    result.peak_bin     = HIST_RES_ADDR_W'(peak_bin_r);
    result.peak_count   = HIST_RES_CNT_W'(peak_count_r);
    result.total        = HIST_RES_TOT_W'(total_r);
    result.nonzero_bins = (HIST_RES_ADDR_W+1)'(nonzero_r);
  end

endmodule

// File: rtl/histogram_stats_reader.sv
// Sweeps every bin of the histogram memory through a 1-cycle-latency read
// port after 'start' and reports peak bin/count, total and non-zero bins.
// Results hold until the next start. rd_en is decoded from the registered
// state and ENA so a stalled cycle issues no read in that same cycle.
// Optional macro HIST_STATS_MIN_EN adds min_bin / min_count outputs.
module histogram_stats_reader
  import hist_pkg::*;
#(
  parameter  int ADDR_W = HIST_ADDR_W,
  parameter  int CNT_W  = HIST_CNT_W,
  localparam int TOT_W  = ADDR_W + CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENA,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CNT_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [CNT_W-1:0]  peak_count,
  output logic [TOT_W-1:0]  total,
`ifdef HIST_STATS_MIN_EN
  output logic [ADDR_W-1:0] min_bin,
  output logic [CNT_W-1:0]  min_count,
`endif
  output logic [ADDR_W:0]   nonzero_bins
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  hist_state_e       state_r;
  hist_state_e       state_s;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              busy_r;
  logic              done_r;
  logic              cap_vld_r;
  logic [ADDR_W-1:0] cap_addr_r;
  logic              rd_en_s;
  logic              scan_start_s;
  hist_result_t      acc_res_s;
  logic              unused_res_s;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; DRAIN waits for the final capture to land.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = READ;
        else       state_s = IDLE;
      end
      READ: begin
        if (ENA && (rd_addr_r == LAST_ADDR)) state_s = DRAIN;
        else                                 state_s = READ;
      end
      DRAIN: begin
        if (!cap_vld_r) state_s = DONE;
        else            state_s = DRAIN;
      end
      DONE: begin
        if (start) state_s = READ;
        else       state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output/control decode from the current state.
  always_comb begin
    rd_en_s      = 1'b0;
    scan_start_s = 1'b0;
    case (state_r)
      IDLE:    scan_start_s = start;
      READ:    rd_en_s      = ENA;
      DRAIN:   rd_en_s      = 1'b0;
      DONE:    scan_start_s = start;
      default: rd_en_s      = 1'b0;
    endcase
  end

  // Address generator: restarts at 0, steps per issued read, never wraps.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_addr_r <= {ADDR_W{1'b0}};
    end else if (scan_start_s) begin
      rd_addr_r <= {ADDR_W{1'b0}};
    end else if (rd_en_s && (rd_addr_r != LAST_ADDR)) begin
      rd_addr_r <= rd_addr_r + ADDR_W'(1'b1);
    end else begin
      rd_addr_r <= rd_addr_r;
    end
  end

  // Registered busy/done status, derived from where the FSM is heading.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == READ) || (state_s == DRAIN);
      done_r <= (state_s == DONE);
    end
  end

  // One-stage pipeline pairing each read with its address for capture.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cap_vld_r  <= 1'b0;
      cap_addr_r <= {ADDR_W{1'b0}};
    end else begin
      cap_vld_r  <= rd_en_s;
      cap_addr_r <= rd_addr_r;
    end
  end

  hist_stats_acc #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_acc (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (scan_start_s),
    .valid     (cap_vld_r),
    .addr      (cap_addr_r),
    .data      (rd_data),
`ifdef HIST_STATS_MIN_EN
    .min_bin   (min_bin),
    .min_count (min_count),
`endif
    .result    (acc_res_s)
  );

  assign rd_en        = rd_en_s;
  assign rd_addr      = rd_addr_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign peak_bin     = acc_res_s.peak_bin[ADDR_W-1:0];
  assign peak_count   = acc_res_s.peak_count[CNT_W-1:0];
  assign total        = acc_res_s.total[TOT_W-1:0];
  assign nonzero_bins = acc_res_s.nonzero_bins[ADDR_W:0];
  // Upper struct bits are zero padding for this configuration.
  assign unused_res_s = ^acc_res_s;

endmodule

// File: tb/tb_histogram_stats_reader.sv
// Directed bench for histogram_stats_reader with a behavioural
// 1-cycle-latency bin memory. Define HIST_STATS_MIN_EN to cover min outputs.
module tb_histogram_stats_reader;

  logic       CLK;
  logic       RST;
  logic       ENA;
  logic       start;
  logic       rd_en;
  logic [6:0] rd_addr;
  logic [6:0] rd_data;
  logic       busy;
  logic       done;
  logic [6:0] peak_bin;
  logic [6:0] peak_count;
  logic [13:0] total;
  logic [7:0] nonzero_bins;
`ifdef HIST_STATS_MIN_EN
  logic [6:0] min_bin;
  logic [6:0] min_count;
`endif

  logic [6:0] mem [128];
  int checks;
  int failures;
  int issued;
  int seq_err;
  int cyc;

  histogram_stats_reader dut (
    .CLK          (CLK),
    .RST          (RST),
    .ENA          (ENA),
    .start        (start),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .peak_bin     (peak_bin),
    .peak_count   (peak_count),
    .total        (total),
`ifdef HIST_STATS_MIN_EN
    .min_bin      (min_bin),
    .min_count    (min_count),
`endif
    .nonzero_bins (nonzero_bins)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bin memory: data appears the cycle after a read strobe.
  always @(posedge CLK) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Read-address sequence monitor: every issued address must be the next one.
  always @(posedge CLK) begin
    if (start && !busy) begin
      issued  <= 0;
      seq_err <= 0;
    end else if (rd_en) begin
      if (int'(rd_addr) != issued) seq_err <= seq_err + 1;
      issued <= issued + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int kind);
    for (int i = 0; i < 128; i++) begin
      if (kind == 2) mem[i] = 7'd127;
      else           mem[i] = 7'd0;
    end
    if (kind == 1) begin
      mem[5]   = 7'd3;
      mem[100] = 7'd9;
      mem[101] = 7'd9;
    end
  endtask

  // mode 1 toggles ENA every cycle; restart_at re-pulses start; abort_at stops early.
  task automatic run_scan(input int mode, input int restart_at, input int abort_at,
                          output int cycles);
    @(negedge CLK);
    start = 1'b1;
    ENA   = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_after_start", 32'(done), 32'd0);
    chk("rd_addr_after_start", 32'(rd_addr), 32'd0);
    cycles = 0;
    while (!done && (cycles < 600) && (cycles != abort_at)) begin
      @(posedge CLK);
      cycles++;
      @(negedge CLK);
      start = (cycles == restart_at);
      if (mode == 1) ENA = ~ENA;
    end
    start = 1'b0;
    ENA   = 1'b1;
  endtask

  task automatic chk_results(input logic [31:0] pb, input logic [31:0] pc,
                             input logic [31:0] tot, input logic [31:0] nz);
    chk("peak_bin", 32'(peak_bin), pb);
    chk("peak_count", 32'(peak_count), pc);
    chk("total", 32'(total), tot);
    chk("nonzero_bins", 32'(nonzero_bins), nz);
    chk("busy_when_done", 32'(busy), 32'd0);
    chk("rd_en_when_done", 32'(rd_en), 32'd0);
  endtask

  task automatic chk_all_zero();
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_peak_bin", 32'(peak_bin), 32'd0);
    chk("rst_peak_count", 32'(peak_count), 32'd0);
    chk("rst_total", 32'(total), 32'd0);
    chk("rst_nonzero", 32'(nonzero_bins), 32'd0);
`ifdef HIST_STATS_MIN_EN
    chk("rst_min_bin", 32'(min_bin), 32'd0);
    chk("rst_min_count", 32'(min_count), 32'd0);
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b0;
    ENA      = 1'b1;
    start    = 1'b0;
    load(0);
    repeat (3) @(negedge CLK);
    chk_all_zero();
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_no_read", 32'(rd_en), 32'd0);

    // All-zero memory.
    run_scan(0, -1, -1, cyc);
    chk("zero_latency", 32'(cyc), 32'd130);
    chk_results(32'd0, 32'd0, 32'd0, 32'd0);
    chk("rd_addr_holds_last", 32'(rd_addr), 32'd127);
    chk("zero_issued", 32'(issued), 32'd128);
`ifdef HIST_STATS_MIN_EN
    chk("zero_min_count", 32'(min_count), 32'd0);
    chk("zero_min_bin", 32'(min_bin), 32'd0);
`endif
    repeat (4) @(negedge CLK);
    chk("done_holds", 32'(done), 32'd1);

    // Sparse memory with a tie at bins 100/101.
    load(1);
    run_scan(0, -1, -1, cyc);
    chk("sparse_latency", 32'(cyc), 32'd130);
    chk_results(32'd100, 32'd9, 32'd21, 32'd3);
`ifdef HIST_STATS_MIN_EN
    chk("sparse_min_count", 32'(min_count), 32'd0);
    chk("sparse_min_bin", 32'(min_bin), 32'd0);
`endif

    // Full memory: every bin at the maximum count.
    load(2);
    run_scan(0, -1, -1, cyc);
    chk("full_latency", 32'(cyc), 32'd130);
    chk_results(32'd0, 32'd127, 32'd16256, 32'd128);
`ifdef HIST_STATS_MIN_EN
    chk("full_min_count", 32'(min_count), 32'd127);
    chk("full_min_bin", 32'(min_bin), 32'd0);
`endif

    // ENA toggling: reads land on odd edges 1..255, done after edge 257.
    load(1);
    run_scan(1, -1, -1, cyc);
    chk("toggle_latency", 32'(cyc), 32'd257);
    chk_results(32'd100, 32'd9, 32'd21, 32'd3);
    chk("toggle_issued", 32'(issued), 32'd128);
    chk("toggle_seq_err", 32'(seq_err), 32'd0);

    // Second start mid-scan is ignored.
    run_scan(0, 40, -1, cyc);
    chk("restart_latency", 32'(cyc), 32'd130);
    chk_results(32'd100, 32'd9, 32'd21, 32'd3);
    chk("restart_seq_err", 32'(seq_err), 32'd0);
    chk("restart_issued", 32'(issued), 32'd128);

    // Reset in the middle of a scan, then a clean rescan.
    run_scan(0, -1, 60, cyc);
    chk("abort_reached", 32'(cyc), 32'd60);
    chk("abort_busy_before", 32'(busy), 32'd1);
    RST = 1'b0;
    #1;
    chk_all_zero();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_reset_busy", 32'(busy), 32'd0);
    run_scan(0, -1, -1, cyc);
    chk("rescan_latency", 32'(cyc), 32'd130);
    chk_results(32'd100, 32'd9, 32'd21, 32'd3);
`ifdef HIST_STATS_MIN_EN
    chk("rescan_min_count", 32'(min_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
